// File: rtl/sound_pkg.sv
// Sound-interface definitions shared by the logo-motion block and sound_player.
package sound_pkg;

    // Sound codes carried on code_sound.
    localparam logic [1:0] SND_STOP = 2'b00;
    localparam logic [1:0] SND_PONG = 2'b01;
    localparam logic [1:0] SND_PING = 2'b10;
    localparam logic [1:0] SND_GO   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TONE = 2'd1,
        ST_GO2  = 2'd2
    } state_t;

    // Largest of three values; sizes the shared half-period counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sound_player_tone_divider.sv
// Square-wave divider: toggles o_sq every (i_last + 1) enabled clocks.
// A restart latches the new terminal count and parks the output low.
module tone_divider
    import sound_pkg::*;
#(
    parameter int HW = 4
)(
    input  logic          clk,
    input  logic          clr,
    input  logic [HW-1:0] i_last,
    input  logic          i_restart,
    input  logic          i_enable,
    output logic          o_sq
);

    logic [HW-1:0] r_last;
    logic [HW-1:0] r_cnt;
    logic          r_sq;

    // Half-period counter 0..last; wraps and toggles the output at last.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_last <= '0;
            r_cnt  <= '0;
            r_sq   <= 1'b0;
        end else if (i_restart) begin
            r_last <= i_last;
            r_cnt  <= '0;
            r_sq   <= 1'b0;
        end else if (i_enable) begin
            if (r_cnt == r_last) begin
                r_cnt <= '0;
                r_sq  <= ~r_sq;
            end else begin
                r_cnt <= r_cnt + HW'(1);
            end
        end
    end

    assign o_sq = r_sq;

endmodule

// File: rtl/sound_player.sv
// Tone generator for the logo-motion sound interface: each new non-stop code
// plays a fixed-length square-wave burst on the speaker pin.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | silent; speaker 0, busy 0, playing 00
// ST_TONE | first (or only) segment at the half-period of the playing code
// ST_GO2  | second segment of a go event, at the ping half-period
module sound_player
    import sound_pkg::*;
#(
    parameter int CLK_HZ    = 25_000_000,
    parameter int PING_HALF = 14205,
    parameter int PONG_HALF = 28409,
    parameter int GO_HALF   = 18939,
    parameter int DUR       = 2_500_000
)(
    input  logic       clk,
    input  logic       clr,
    input  logic       mute,
    input  logic [1:0] code_sound,
    output logic       speaker,
    output logic       busy,
    output logic [1:0] playing
);

    localparam int HW = $clog2(max3(PING_HALF, PONG_HALF, GO_HALF));
    localparam int DW = $clog2(DUR);

    // Terminal counts are stored as HALF-1 / DUR-1 so they fit the counter width.
    localparam logic [HW-1:0] PING_LAST = HW'(PING_HALF - 1);
    localparam logic [HW-1:0] PONG_LAST = HW'(PONG_HALF - 1);
    localparam logic [HW-1:0] GO_LAST   = HW'(GO_HALF - 1);
    localparam logic [DW-1:0] DUR_LAST  = DW'(DUR - 1);

    if (PING_HALF < 2 || PONG_HALF < 2 || GO_HALF < 2 || DUR < 2 || CLK_HZ <= 0) begin : g_param_check
        $error("sound_player: every half-period and DUR must be at least 2");
    end

    state_t        r_state;
    state_t        w_state_nxt;
    logic [1:0]    r_code_q;
    logic [DW-1:0] r_dur;
    logic          r_busy;
    logic [1:0]    r_playing;

    logic          w_trig;
    logic          w_dur_done;
    logic          w_load_go2;
    logic          w_restart;
    logic          w_enable;
    logic [HW-1:0] w_last_sel;
    logic          w_busy_nxt;
    logic [1:0]    w_playing_nxt;
    logic          w_sq;

    // A new, non-stop code while unmuted starts a tone.
    assign w_trig     = (code_sound != r_code_q) && (code_sound != SND_STOP) && !mute;
    assign w_dur_done = (r_dur == DUR_LAST);

    // State register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: mute beats a trigger, a trigger beats segment completion.
    always_comb begin
        w_state_nxt = r_state;
        if (mute) begin
            w_state_nxt = ST_IDLE;
        end else if (w_trig) begin
            w_state_nxt = ST_TONE;
        end else begin
            case (r_state)
                ST_TONE: begin
                    if (w_dur_done) begin
                        w_state_nxt = (r_playing == SND_GO) ? ST_GO2 : ST_IDLE;
                    end
                end
                ST_GO2: begin
                    if (w_dur_done) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Per-transition controls for the divider, duration counter and status outputs.
    always_comb begin
        w_load_go2    = (r_state == ST_TONE) && (w_state_nxt == ST_GO2);
        w_restart     = w_trig || w_load_go2 || (w_state_nxt == ST_IDLE);
        w_enable      = !w_restart;
        w_last_sel    = PING_LAST;
        if (w_trig) begin
            case (code_sound)
                SND_PONG: w_last_sel = PONG_LAST;
                SND_GO:   w_last_sel = GO_LAST;
                default:  w_last_sel = PING_LAST;
            endcase
        end
        w_busy_nxt    = (w_state_nxt != ST_IDLE);
        w_playing_nxt = r_playing;
        if (w_state_nxt == ST_IDLE) begin
            w_playing_nxt = SND_STOP;
        end else if (w_trig) begin
            w_playing_nxt = code_sound;
        end
    end

    // Previous code; updates while muted so a muted change is swallowed.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_code_q <= SND_STOP;
        end else begin
            r_code_q <= code_sound;
        end
    end

    // Segment duration counter 0..DUR-1, cleared at every segment start and in idle.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_dur <= '0;
        end else if (w_restart) begin
            r_dur <= '0;
        end else begin
            r_dur <= r_dur + DW'(1);
        end
    end

    // Registered status outputs.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_busy    <= 1'b0;
            r_playing <= SND_STOP;
        end else begin
            r_busy    <= w_busy_nxt;
            r_playing <= w_playing_nxt;
        end
    end

    tone_divider #(
        .HW (HW)
    ) u_tone_divider (
        .clk       (clk),
        .clr       (clr),
        .i_last    (w_last_sel),
        .i_restart (w_restart),
        .i_enable  (w_enable),
        .o_sq      (w_sq)
    );

    assign speaker = w_sq;
    assign busy    = r_busy;
    assign playing = r_playing;

endmodule

// File: tb/tb_sound_player.sv
// Bench for sound_player: elapsed-time tone model checked every cycle,
// directed scenarios with hand-computed burst statistics, then random codes.
module tb_sound_player;
    import sound_pkg::*;

    localparam int P_PING = 4;
    localparam int P_PONG = 8;
    localparam int P_GO   = 6;
    localparam int P_DUR  = 40;

    logic       clk = 1'b0;
    logic       clr;
    logic       mute;
    logic [1:0] code_sound;
    logic       speaker;
    logic       busy;
    logic [1:0] playing;

    always #5 clk = ~clk;

    sound_player #(
        .CLK_HZ    (25_000_000),
        .PING_HALF (P_PING),
        .PONG_HALF (P_PONG),
        .GO_HALF   (P_GO),
        .DUR       (P_DUR)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .mute       (mute),
        .code_sound (code_sound),
        .speaker    (speaker),
        .busy       (busy),
        .playing    (playing)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: whether a tone is active, its code, and edges elapsed since the trigger.
    logic       m_active = 1'b0;
    logic [1:0] m_code   = 2'b00;
    logic [1:0] m_prev   = 2'b00;
    int         m_k      = 0;

    // Measurements from DUT outputs, plus model busy time.
    int   cnt_busy  = 0;
    int   cnt_mbusy = 0;
    int   cnt_rise  = 0;
    int   cnt_play [4] = '{0, 0, 0, 0};
    logic prev_spk  = 1'b0;

    int b0, mb0, r0, p0;

    function automatic int half_of(input logic [1:0] c);
        case (c)
            SND_PONG: return P_PONG;
            SND_GO:   return P_GO;
            default:  return P_PING;
        endcase
    endfunction

    function automatic int total_of(input logic [1:0] c);
        return (c == SND_GO) ? 2 * P_DUR : P_DUR;
    endfunction

    function automatic logic spk_of(input logic [1:0] c, input int k);
        int h;
        int kk;
        h  = half_of(c);
        kk = k;
        if (c == SND_GO && k >= P_DUR) begin
            kk = k - P_DUR;
            h  = P_PING;
        end
        return ((kk / h) % 2) == 1;
    endfunction

    task automatic chk(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s t=%0t got %0d want %0d", name, $time, got, want);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_code   = 2'b00;
        m_prev   = 2'b00;
        m_k      = 0;
    endtask

    // Advance the model by one clock edge using the inputs the DUT just sampled.
    task automatic model_step();
        if (clr) begin
            model_reset();
        end else begin
            if (mute) begin
                m_active = 1'b0;
            end else if (code_sound != m_prev && code_sound != SND_STOP) begin
                m_active = 1'b1;
                m_code   = code_sound;
                m_k      = 0;
            end else if (m_active) begin
                m_k++;
                if (m_k >= total_of(m_code)) m_active = 1'b0;
            end
            m_prev = code_sound;
        end
    endtask

    task automatic compare_cycle();
        logic [1:0] exp_play;
        logic       exp_spk;
        exp_play = m_active ? m_code : 2'b00;
        exp_spk  = m_active ? spk_of(m_code, m_k) : 1'b0;
        chk("busy",    int'(busy),    int'(m_active));
        chk("playing", int'(playing), int'(exp_play));
        chk("speaker", int'(speaker), int'(exp_spk));
        if (busy) cnt_busy++;
        if (m_active) cnt_mbusy++;
        cnt_play[playing]++;
        if (speaker && !prev_spk) cnt_rise++;
        prev_spk = speaker;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            #1;
            compare_cycle();
        end
    endtask

    task automatic snap();
        b0  = cnt_busy;
        mb0 = cnt_mbusy;
        r0  = cnt_rise;
    endtask

    task automatic burst_check(input string tag, input int want_busy, input int want_rise);
        chk({tag, "_busy_cycles"},  cnt_busy - b0,   want_busy);
        chk({tag, "_model_busy"},   cnt_mbusy - mb0, want_busy);
        chk({tag, "_speaker_rises"}, cnt_rise - r0,  want_rise);
    endtask

    initial begin
        clr        = 1'b1;
        mute       = 1'b0;
        code_sound = SND_STOP;
        #22;
        chk("rst_busy",    int'(busy),    0);
        chk("rst_playing", int'(playing), 0);
        chk("rst_speaker", int'(speaker), 0);
        clr = 1'b0;
        tick(3);

        // Ping held: one burst, period 8, no retrigger.
        snap();
        code_sound = SND_PING;
        tick(100);
        burst_check("ping_hold", 40, 5);

        // Pong, stop, pong 50 cycles apart: two bursts of period 16.
        code_sound = SND_STOP;
        tick(5);
        snap();
        p0 = cnt_play[1];
        code_sound = SND_PONG;
        tick(45);
        code_sound = SND_STOP;
        tick(5);
        code_sound = SND_PONG;
        tick(60);
        burst_check("pong_twice", 80, 4);
        chk("pong_playing_01_cycles", cnt_play[1] - p0, 80);

        // Go: 660 Hz then 880 Hz segments.
        code_sound = SND_STOP;
        tick(5);
        snap();
        p0 = cnt_play[3];
        code_sound = SND_GO;
        tick(100);
        burst_check("go", 80, 8);
        chk("go_playing_11_cycles", cnt_play[3] - p0, 80);

        // Ping preempted by pong after 10 cycles.
        code_sound = SND_STOP;
        tick(5);
        snap();
        code_sound = SND_PING;
        tick(10);
        code_sound = SND_PONG;
        tick(60);
        burst_check("preempt", 50, 3);

        // Mute during pong, change code while muted, unmute: silence.
        code_sound = SND_STOP;
        tick(5);
        snap();
        code_sound = SND_PONG;
        tick(15);
        mute = 1'b1;
        tick(1);
        chk("mute_busy_now", int'(busy), 0);
        code_sound = SND_PING;
        tick(3);
        mute = 1'b0;
        tick(20);
        burst_check("mute", 15, 1);

        // Asynchronous clear mid-burst, then a fresh ping burst.
        code_sound = SND_STOP;
        tick(5);
        code_sound = SND_PING;
        tick(13);
        #3;
        clr = 1'b1;
        #1;
        chk("clr_async_busy",    int'(busy),    0);
        chk("clr_async_playing", int'(playing), 0);
        chk("clr_async_speaker", int'(speaker), 0);
        model_reset();
        prev_spk = 1'b0;
        tick(2);
        #2;
        clr = 1'b0;
        snap();
        tick(50);
        burst_check("after_clr", 40, 5);

        // Random codes, hold times and mute pulses.
        for (int i = 0; i < 80; i++) begin
            code_sound = 2'($urandom_range(0, 3));
            mute       = ($urandom_range(0, 9) == 0);
            tick(int'($urandom_range(1, 3)));
            mute = 1'b0;
            if ($urandom_range(0, 4) == 0) tick(90);
            else tick(int'($urandom_range(1, 45)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
